z80_io_responder: RTL and testbench

Bus-side I/O port responder for the Z80 core. It is the peripheral end of the `IN A,(n)`/`IN r,(C)` and `OUT (n),A`/`OUT (C),r` I/O machine cycles. It decodes `IORQ_N`/`RD_N`/`WR_N` against a contiguous window of low-byte port addresses and inserts programmable wait states. On reads it drives port data onto the bus; on writes it latches bus data into per-port registers. It is used in the system testbench and formal harness as the device that answers the CPU's I/O cycles.

---
 rtl/z80_io_pkg.sv | 15 +
 rtl/z80_io_responder_decode.sv | 27 ++
 rtl/z80_io_responder.sv | 204 ++++++++++++++++++++
 tb/tb_z80_io_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_io_pkg.sv
// z80_io_pkg: shared types for the Z80 I/O port responder.
// Holds the responder state encoding and port-window limits.
package z80_io_pkg;

  localparam int IO_IDX_W     = 4;
  localparam int IO_MAX_PORTS = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    WHOLD
  } io_state_t;

endpackage

// File: rtl/z80_io_responder_decode.sv
// z80_io_decode: combinational I/O port window decoder.
// Compares in 9 bits so the window never wraps past 0xFF.
module z80_io_decode
  import z80_io_pkg::*;
#(
  parameter logic [7:0] PORT_BASE = 8'h10,
  parameter int         NUM_PORTS = 4
) (
  input  logic [7:0]          port,
  input  logic                iorq_n,
  input  logic                m1_n,
  output logic                sel,
  output logic [IO_IDX_W-1:0] idx
);

  localparam logic [8:0] BASE9 = {1'b0, PORT_BASE};
  localparam logic [8:0] TOP9  = BASE9 + 9'(NUM_PORTS);

  logic [8:0] port9;

  assign port9 = {1'b0, port};

  // Interrupt acknowledge (M1 low with IORQ) is never a port access.
  assign sel = !iorq_n && m1_n && (port9 >= BASE9) && (port9 < TOP9);
  assign idx = IO_IDX_W'(port - PORT_BASE);

endmodule

// File: rtl/z80_io_responder.sv
// z80_io_responder: peripheral end of Z80 IN/OUT machine cycles.
// Decodes a port window, inserts waits, drives reads, latches writes.
module z80_io_responder
  import z80_io_pkg::*;
#(
  parameter logic [7:0] PORT_BASE   = 8'h10,
  parameter int         NUM_PORTS   = 4,
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            addr,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  output logic                   data_out_en,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   m1_n,
  output logic                   wait_n,
  input  logic [8*NUM_PORTS-1:0] port_in,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic                   rd_strobe,
  output logic                   wr_strobe,
  output logic [IO_IDX_W-1:0]    strobe_idx,
  output logic [7:0]             strobe_hi,
  output logic                   proto_err
);

  if (NUM_PORTS < 1 || NUM_PORTS > IO_MAX_PORTS ||
      (int'(PORT_BASE) + NUM_PORTS) > 256 ||
      WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_param_chk
    $error("z80_io_responder: illegal parameters");
  end

  localparam logic [2:0] WS3 = 3'(WAIT_STATES);
  localparam logic [8*NUM_PORTS-1:0] PORT_RST = {NUM_PORTS{RESET_VAL}};

  logic                sel;
  logic [IO_IDX_W-1:0] idx;

  z80_io_decode #(
    .PORT_BASE(PORT_BASE),
    .NUM_PORTS(NUM_PORTS)
  ) u_decode (
    .port  (addr[7:0]),
    .iorq_n(iorq_n),
    .m1_n  (m1_n),
    .sel   (sel),
    .idx   (idx)
  );

  io_state_t             state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  tgt_wr_q, tgt_wr_d;
  logic [IO_IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]            hi_q, hi_d;
  logic                  arm_q, arm_d;
  logic [7:0]            data_out_q, data_out_d;
  logic                  data_out_en_q, data_out_en_d;
  logic                  wait_n_q, wait_n_d;
  logic [8*NUM_PORTS-1:0] port_out_q, port_out_d;
  logic                  rd_strobe_q, rd_strobe_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [IO_IDX_W-1:0]   strobe_idx_q, strobe_idx_d;
  logic [7:0]            strobe_hi_q, strobe_hi_d;
  logic                  proto_err_q, proto_err_d;
  logic                  enter_rd, enter_wr;

  // Next-state and next-output logic for the bus cycle FSM.
  // arm gates IDLE so a held strobe cannot start a second cycle
  // until IORQ has been seen high.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tgt_wr_d     = tgt_wr_q;
    idx_d        = idx_q;
    hi_d         = hi_q;
    arm_d        = iorq_n ? 1'b1 : arm_q;
    data_out_d   = data_out_q;
    port_out_d   = port_out_q;
    rd_strobe_d  = 1'b0;
    wr_strobe_d  = 1'b0;
    strobe_idx_d = strobe_idx_q;
    strobe_hi_d  = strobe_hi_q;
    proto_err_d  = 1'b0;
    enter_rd     = 1'b0;
    enter_wr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel && arm_q) begin
          if (!rd_n && !wr_n) begin
            proto_err_d = 1'b1;
            arm_d       = 1'b0;
          end else if (!rd_n || !wr_n) begin
            arm_d    = 1'b0;
            idx_d    = idx;
            hi_d     = addr[15:8];
            tgt_wr_d = !wr_n;
            if (WAIT_STATES == 0) begin
              enter_rd = wr_n;
              enter_wr = !wr_n;
            end else begin
              state_d = WAIT;
              cnt_d   = WS3;
            end
          end
        end
      end
      WAIT: begin
        if (iorq_n || (tgt_wr_q ? wr_n : rd_n)) begin
          state_d = IDLE;
        end else if (cnt_q <= 3'd1) begin
          enter_rd = !tgt_wr_q;
          enter_wr = tgt_wr_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      READ: begin
        if (iorq_n || rd_n) begin
          state_d      = IDLE;
          rd_strobe_d  = 1'b1;
          strobe_idx_d = idx_q;
          strobe_hi_d  = hi_q;
        end
      end
      WHOLD: begin
        if (iorq_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enter_rd) begin
      state_d = READ;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (IO_IDX_W'(k) == idx_d) data_out_d = port_in[8*k +: 8];
      end
    end

    if (enter_wr) begin
      state_d      = WHOLD;
      wr_strobe_d  = 1'b1;
      strobe_idx_d = idx_d;
      strobe_hi_d  = hi_d;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (IO_IDX_W'(k) == idx_d) port_out_d[8*k +: 8] = data_in;
      end
    end

    wait_n_d      = (state_d != WAIT);
    data_out_en_d = (state_d == READ);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tgt_wr_q      <= 1'b0;
      idx_q         <= '0;
      hi_q          <= '0;
      arm_q         <= 1'b1;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
      wait_n_q      <= 1'b1;
      port_out_q    <= PORT_RST;
      rd_strobe_q   <= 1'b0;
      wr_strobe_q   <= 1'b0;
      strobe_idx_q  <= '0;
      strobe_hi_q   <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tgt_wr_q      <= tgt_wr_d;
      idx_q         <= idx_d;
      hi_q          <= hi_d;
      arm_q         <= arm_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
      wait_n_q      <= wait_n_d;
      port_out_q    <= port_out_d;
      rd_strobe_q   <= rd_strobe_d;
      wr_strobe_q   <= wr_strobe_d;
      strobe_idx_q  <= strobe_idx_d;
      strobe_hi_q   <= strobe_hi_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_out_en = data_out_en_q;
  assign wait_n      = wait_n_q;
  assign port_out    = port_out_q;
  assign rd_strobe   = rd_strobe_q;
  assign wr_strobe   = wr_strobe_q;
  assign strobe_idx  = strobe_idx_q;
  assign strobe_hi   = strobe_hi_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_z80_io_responder.sv
// tb_z80_io_responder: randomized and directed bench for the responder.
// Expectations come from a transaction-level model of the I/O window.
module tb_z80_io_responder;

  localparam int         NP   = 4;
  localparam int         WS   = 2;
  localparam logic [7:0] BASE = 8'h10;
  localparam logic [7:0] RV   = 8'hC3;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   addr;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          data_out_en;
  logic          iorq_n, rd_n, wr_n, m1_n;
  logic          wait_n;
  logic [8*NP-1:0] port_in;
  logic [8*NP-1:0] port_out;
  logic          rd_strobe, wr_strobe;
  logic [3:0]    strobe_idx;
  logic [7:0]    strobe_hi;
  logic          proto_err;

  always #5 clk = ~clk;

  z80_io_responder #(
    .PORT_BASE(BASE),
    .NUM_PORTS(NP),
    .WAIT_STATES(WS),
    .RESET_VAL(RV)
  ) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_out_en(data_out_en),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .wait_n(wait_n), .port_in(port_in), .port_out(port_out),
    .rd_strobe(rd_strobe), .wr_strobe(wr_strobe),
    .strobe_idx(strobe_idx), .strobe_hi(strobe_hi),
    .proto_err(proto_err)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] exp_port [NP];
  logic [3:0] exp_sidx;
  logic [7:0] exp_shi;

  int o_wlo, o_wfirst, o_en, o_rds, o_wrs, o_perr, tk;
  logic [7:0] o_data;
  logic o_seen;

  function automatic logic [8*NP-1:0] exp_vec();
    logic [8*NP-1:0] v;
    for (int k = 0; k < NP; k++) v[8*k +: 8] = exp_port[k];
    return v;
  endfunction

  task automatic clear_obs();
    o_wlo = 0; o_wfirst = -1; o_en = 0; o_rds = 0;
    o_wrs = 0; o_perr = 0; tk = 0; o_data = '0; o_seen = 1'b0;
  endtask

  // one clock, then sample the registered outputs just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (!wait_n) begin
      if (o_wlo == 0) o_wfirst = tk;
      o_wlo++;
    end
    if (data_out_en) begin
      if (!o_seen) o_data = data_out;
      o_seen = 1'b1;
      o_en++;
    end
    if (rd_strobe) o_rds++;
    if (wr_strobe) o_wrs++;
    if (proto_err) o_perr++;
    tk++;
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  // full I/O cycle: strobes held for WS+1+hold clocks, then two idle clocks
  task automatic io_cycle(input bit wr, input logic [15:0] a,
                          input logic [7:0] d, input bit m1, input int hold);
    clear_obs();
    addr = a; data_in = d; m1_n = m1;
    iorq_n = 1'b0; rd_n = wr; wr_n = !wr;
    repeat (WS + 1 + hold) tick();
    bus_idle();
    repeat (2) tick();
  endtask

  task automatic test_reset();
    bus_idle();
    addr = '0; data_in = '0; port_in = '0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < NP; k++) exp_port[k] = RV;
    exp_sidx = '0; exp_shi = '0;
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL reset_wait_n got=%b exp=1", wait_n); end
    total++; if (data_out_en !== 1'b0 || data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%b/%h exp=0/00", data_out_en, data_out); end
    total++; if (port_out !== exp_vec()) begin bad++; $display("FAIL reset_port_out got=%h exp=%h", port_out, exp_vec()); end
    total++; if ({rd_strobe, wr_strobe, proto_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {rd_strobe, wr_strobe, proto_err}); end
    total++; if (strobe_idx !== 4'h0 || strobe_hi !== 8'h00) begin bad++; $display("FAIL reset_strobe_info got=%h/%h exp=0/00", strobe_idx, strobe_hi); end
  endtask

  task automatic test_read();
    port_in = 32'h0000_A500 | 32'($urandom_range(0, 255));
    clear_obs();
    addr = 16'h3C11; m1_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
    tick();
    total++; if (wait_n !== 1'b0) begin bad++; $display("FAIL rd_wait_first got=%b exp=0", wait_n); end
    tick();
    total++; if (wait_n !== 1'b0 || data_out_en !== 1'b0) begin bad++; $display("FAIL rd_wait_second got=%b/%b exp=0/0", wait_n, data_out_en); end
    tick();
    total++; if (wait_n !== 1'b1 || data_out_en !== 1'b1 || data_out !== 8'hA5) begin bad++; $display("FAIL rd_data got=%b/%b/%h exp=1/1/a5", wait_n, data_out_en, data_out); end
    bus_idle();
    tick();
    total++; if (rd_strobe !== 1'b1 || data_out_en !== 1'b0) begin bad++; $display("FAIL rd_exit got=%b/%b exp=1/0", rd_strobe, data_out_en); end
    total++; if (strobe_idx !== 4'd1 || strobe_hi !== 8'h3C) begin bad++; $display("FAIL rd_strobe_info got=%h/%h exp=1/3c", strobe_idx, strobe_hi); end
    tick();
    total++; if (o_rds !== 1 || o_wlo !== WS) begin bad++; $display("FAIL rd_counts got=%0d/%0d exp=1/%0d", o_rds, o_wlo, WS); end
    exp_sidx = 4'd1; exp_shi = 8'h3C;
  endtask

  task automatic test_write();
    clear_obs();
    addr = 16'h5A13; data_in = 8'h5A; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (WS) tick();
    total++; if (port_out[31:24] !== exp_port[3]) begin bad++; $display("FAIL wr_early got=%h exp=%h", port_out[31:24], exp_port[3]); end
    tick();
    exp_port[3] = 8'h5A; exp_sidx = 4'd3; exp_shi = 8'h5A;
    total++; if (port_out !== exp_vec() || wr_strobe !== 1'b1) begin bad++; $display("FAIL wr_entry got=%h/%b exp=%h/1", port_out, wr_strobe, exp_vec()); end
    repeat (5) tick();
    bus_idle();
    repeat (2) tick();
    total++; if (o_wrs !== 1 || o_rds !== 0) begin bad++; $display("FAIL wr_single got=%0d/%0d exp=1/0", o_wrs, o_rds); end
    total++; if (strobe_idx !== exp_sidx || strobe_hi !== exp_shi) begin bad++; $display("FAIL wr_strobe_info got=%h/%h exp=%h/%h", strobe_idx, strobe_hi, exp_sidx, exp_shi); end
  endtask

  task automatic test_unselected();
    io_cycle(1'b0, 16'h7714, 8'h00, 1'b1, 1);
    total++; if (o_wlo + o_en + o_rds + o_wrs !== 0) begin bad++; $display("FAIL unsel_14 got=%0d/%0d/%0d/%0d exp=0/0/0/0", o_wlo, o_en, o_rds, o_wrs); end
    io_cycle(1'b1, 16'h770F, 8'hEE, 1'b0, 1);
    total++; if (o_wlo + o_en + o_rds + o_wrs !== 0 || port_out !== exp_vec()) begin bad++; $display("FAIL unsel_0f_m1 got=%0d/%0d/%h exp=0/0/%h", o_wlo, o_wrs, port_out, exp_vec()); end
    io_cycle(1'b0, 16'h7711, 8'h00, 1'b0, 1);
    total++; if (o_wlo + o_en + o_rds !== 0) begin bad++; $display("FAIL unsel_11_m1 got=%0d/%0d/%0d exp=0/0/0", o_wlo, o_en, o_rds); end
    total++; if (strobe_idx !== exp_sidx || strobe_hi !== exp_shi) begin bad++; $display("FAIL unsel_info got=%h/%h exp=%h/%h", strobe_idx, strobe_hi, exp_sidx, exp_shi); end
  endtask

  task automatic test_proto();
    clear_obs();
    addr = 16'h1112; data_in = 8'h99; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    tick();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_pulse got=%b exp=1", proto_err); end
    bus_idle();
    repeat (2) tick();
    total++; if (o_perr !== 1 || o_wlo + o_en + o_rds + o_wrs !== 0) begin bad++; $display("FAIL proto_quiet got=%0d/%0d/%0d exp=1/0/0", o_perr, o_wlo, o_wrs); end
    total++; if (port_out !== exp_vec()) begin bad++; $display("FAIL proto_ports got=%h exp=%h", port_out, exp_vec()); end
  endtask

  task automatic test_abort_and_reset();
    clear_obs();
    addr = 16'h2211; iorq_n = 1'b0; rd_n = 1'b0;
    tick();
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (2) tick();
    total++; if (wait_n !== 1'b1 || o_wlo !== 1 || o_rds + o_en !== 0) begin bad++; $display("FAIL abort got=%b/%0d/%0d exp=1/1/0", wait_n, o_wlo, o_rds); end
    clear_obs();
    addr = 16'h4412; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (WS + 1) tick();
    total++; if (data_out_en !== 1'b1) begin bad++; $display("FAIL rst_pre_read got=%b exp=1", data_out_en); end
    reset = 1'b1;
    tick();
    for (int k = 0; k < NP; k++) exp_port[k] = RV;
    exp_sidx = '0; exp_shi = '0;
    total++; if (data_out_en !== 1'b0 || wait_n !== 1'b1 || port_out !== exp_vec()) begin bad++; $display("FAIL rst_mid got=%b/%b/%h exp=0/1/%h", data_out_en, wait_n, port_out, exp_vec()); end
    reset = 1'b0;
    bus_idle();
    repeat (2) tick();
    total++; if (o_rds !== 0 || strobe_idx !== 4'd0 || strobe_hi !== 8'd0) begin bad++; $display("FAIL rst_no_strobe got=%0d/%h/%h exp=0/0/00", o_rds, strobe_idx, strobe_hi); end
  endtask

  task automatic test_retrigger();
    clear_obs();
    port_in = $urandom();
    addr = 16'h0910; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (WS + 1) tick();
    rd_n = 1'b1;
    tick();
    rd_n = 1'b0;
    repeat (WS + 2) tick();
    bus_idle();
    repeat (2) tick();
    total++; if (o_rds !== 1 || o_wlo !== WS || o_en !== 1) begin bad++; $display("FAIL retrigger got=%0d/%0d/%0d exp=1/%0d/1", o_rds, o_wlo, o_en, WS); end
    exp_sidx = 4'd0; exp_shi = 8'h09;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    d = 8'($urandom());
    port_in = $urandom();
    io_cycle(1'b1, 16'hAB10, d, 1'b1, 0);
    exp_port[0] = d;
    total++; if (o_wrs !== 1 || port_out !== exp_vec()) begin bad++; $display("FAIL b2b_write got=%0d/%h exp=1/%h", o_wrs, port_out, exp_vec()); end
    io_cycle(1'b0, 16'hCD10, 8'h00, 1'b1, 0);
    total++; if (o_rds !== 1 || o_wrs !== 0 || o_data !== port_in[7:0] || o_wfirst !== 0) begin bad++; $display("FAIL b2b_read got=%0d/%0d/%h/%0d exp=1/0/%h/0", o_rds, o_wrs, o_data, o_wfirst, port_in[7:0]); end
    total++; if (strobe_idx !== 4'd0 || strobe_hi !== 8'hCD) begin bad++; $display("FAIL b2b_info got=%h/%h exp=0/cd", strobe_idx, strobe_hi); end
    exp_sidx = 4'd0; exp_shi = 8'hCD;
  endtask

  task automatic test_random();
    bit wr, m1, sel;
    int lo, idx, hold;
    logic [15:0] a;
    logic [7:0] d, exp_d;
    for (int it = 0; it < 40; it++) begin
      port_in = $urandom();
      lo = int'(BASE) - 4 + int'($urandom_range(0, 11));
      a = {8'($urandom()), 8'(lo)};
      wr = 1'($urandom());
      m1 = ($urandom_range(0, 5) != 0);
      hold = int'($urandom_range(0, 3));
      d = 8'($urandom());
      sel = m1 && lo >= int'(BASE) && lo < int'(BASE) + NP;
      idx = lo - int'(BASE);
      exp_d = sel ? port_in[8*idx +: 8] : 8'h00;
      io_cycle(wr, a, d, m1, hold);
      if (sel) begin
        exp_sidx = 4'(idx);
        exp_shi = a[15:8];
        if (wr) exp_port[idx] = d;
      end
      total++; if (o_wlo !== (sel ? WS : 0) || (sel && o_wfirst !== 0)) begin bad++; $display("FAIL rnd_wait it=%0d got=%0d@%0d exp=%0d", it, o_wlo, o_wfirst, sel ? WS : 0); end
      total++; if (o_rds !== int'(sel && !wr) || o_wrs !== int'(sel && wr)) begin bad++; $display("FAIL rnd_strobes it=%0d got=%0d/%0d exp=%0d/%0d", it, o_rds, o_wrs, int'(sel && !wr), int'(sel && wr)); end
      total++; if (o_en !== ((sel && !wr) ? hold + 1 : 0)) begin bad++; $display("FAIL rnd_en it=%0d got=%0d exp=%0d", it, o_en, (sel && !wr) ? hold + 1 : 0); end
      if (sel && !wr) begin
        total++; if (o_data !== exp_d) begin bad++; $display("FAIL rnd_data it=%0d got=%h exp=%h", it, o_data, exp_d); end
      end
      total++; if (port_out !== exp_vec()) begin bad++; $display("FAIL rnd_ports it=%0d got=%h exp=%h", it, port_out, exp_vec()); end
      total++; if (strobe_idx !== exp_sidx || strobe_hi !== exp_shi) begin bad++; $display("FAIL rnd_info it=%0d got=%h/%h exp=%h/%h", it, strobe_idx, strobe_hi, exp_sidx, exp_shi); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_idle();
    addr = '0;
    data_in = '0;
    port_in = '0;
    test_reset();
    test_read();
    test_write();
    test_unselected();
    test_proto();
    test_abort_and_reset();
    test_retrigger();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
